// File: rtl/mips_mem_unit_pkg.sv
// Shared definitions for the unified MIPS instruction/data memory:
// FSM state encoding, access-size encoding and the address fault rule.
package mips_mem_unit_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    MEM_WAIT   = 2'd1,
    MEM_ACCESS = 2'd2,
    MEM_DONE   = 2'd3
  } mem_state_t;

  localparam logic SZ_WORD = 1'b0;
  localparam logic SZ_BYTE = 1'b1;

  // A word access must be 4-byte aligned, and every access must land inside
  // the array; upper address bits are range-checked, never aliased.
  function automatic logic addr_fault(input logic size, input logic [31:0] addr,
                                      input int unsigned depth);
    logic misaligned;
    logic out_of_range;
    misaligned   = (size == SZ_WORD) && (addr[1:0] != 2'b00);
    out_of_range = ({2'b00, addr[31:2]} >= depth);
    return misaligned || out_of_range;
  endfunction

endpackage

// File: rtl/mips_mem_unit_if.sv
// Core-side request bus plus program-load port of the unified memory.
interface mips_mem_unit_if #(
  parameter int ADDR_W = 10
) ();
  logic              req;
  logic              we;
  logic              size;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ready;
  logic              err;
  logic              busy;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [31:0]       prog_data;

  modport master (
    output req, we, size, addr, wdata, prog_we, prog_addr, prog_data,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  req, we, size, addr, wdata, prog_we, prog_addr, prog_data,
    output rdata, ready, err, busy
  );
endinterface

// File: rtl/mips_mem_unit_byte_lane.sv
// Big-endian byte lane helper: merges one byte into a word for sb and
// extracts one byte for byte reads. Offset 0 is bits [31:24].
module mips_byte_lane (
  input  logic [31:0] old_word,
  input  logic [1:0]  byte_off,
  input  logic [7:0]  byte_in,
  output logic [31:0] merged_word,
  output logic [7:0]  lane_out
);

  // Select the addressed lane for both the merge and the extract paths.
  always_comb begin
    merged_word = old_word;
    lane_out    = old_word[31:24];
    case (byte_off)
      2'd0: begin
        merged_word[31:24] = byte_in;
        lane_out           = old_word[31:24];
      end
      2'd1: begin
        merged_word[23:16] = byte_in;
        lane_out           = old_word[23:16];
      end
      2'd2: begin
        merged_word[15:8] = byte_in;
        lane_out          = old_word[15:8];
      end
      default: begin
        merged_word[7:0] = byte_in;
        lane_out         = old_word[7:0];
      end
    endcase
  end

endmodule

// File: rtl/mips_mem_unit.sv
// Unified instruction/data memory for the multicycle MIPS core.
// One request at a time through req/ready with WAIT_STATES stall cycles;
// a program-load port writes whole words while the unit is idle.
module mips_mem_unit
  import mips_mem_unit_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input logic           clock,
  input logic           reset_n,
  mips_mem_unit_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam int WS_M1  = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

  mem_state_t        state_q;
  logic [3:0]        cnt_q;
  logic              ready_q;
  logic              err_q;
  logic [31:0]       rdata_q;

  logic [31:0]       addr_q;
  logic              we_q;
  logic              size_q;
  logic [31:0]       wdata_q;

  logic [31:0]       mem [DEPTH_WORDS];

  logic              accept;
  logic              prog_wr;
  logic              mem_wr;
  logic              fault;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       old_word;
  logic [31:0]       merged_word;
  logic [7:0]        lane_out;
  logic [31:0]       store_word;
  logic [31:0]       read_word;

  // Program writes take priority over a simultaneous request in IDLE.
  assign prog_wr  = reset_n && (state_q == MEM_IDLE) && bus.prog_we;
  assign accept   = (state_q == MEM_IDLE) && bus.req && !bus.prog_we;

  assign word_idx = addr_q[ADDR_W+1:2];
  assign old_word = mem[word_idx];
  assign fault    = addr_fault(size_q, addr_q, DEPTH_WORDS);

  mips_byte_lane u_lane (
    .old_word    (old_word),
    .byte_off    (addr_q[1:0]),
    .byte_in     (wdata_q[7:0]),
    .merged_word (merged_word),
    .lane_out    (lane_out)
  );

  assign store_word = (size_q == SZ_BYTE) ? merged_word : wdata_q;
  assign read_word  = (size_q == SZ_BYTE) ? {24'h0, lane_out} : old_word;
  assign mem_wr     = (state_q == MEM_ACCESS) && we_q && !fault;

  assign bus.busy  = (state_q != MEM_IDLE);
  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

  // Capture the request fields on the accepting edge; held until the next accept.
  always_ff @(posedge clock) begin
    if (accept) begin
      addr_q  <= bus.addr;
      we_q    <= bus.we;
      size_q  <= bus.size;
      wdata_q <= bus.wdata;
    end
  end

  // Memory array: program-load writes in IDLE, core writes only on the ACCESS edge.
  always_ff @(posedge clock) begin
    if (prog_wr) begin
      mem[bus.prog_addr] <= bus.prog_data;
    end else if (mem_wr) begin
      mem[word_idx] <= store_word;
    end
  end

  // Access FSM with wait counter and registered ready/err/rdata.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MEM_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      case (state_q)
        MEM_IDLE: begin
          if (accept) begin
            if (WAIT_STATES > 0) begin
              state_q <= MEM_WAIT;
              cnt_q   <= 4'(WS_M1);
            end else begin
              state_q <= MEM_ACCESS;
            end
          end
        end
        MEM_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= MEM_ACCESS;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        MEM_ACCESS: begin
          ready_q <= 1'b1;
          err_q   <= fault;
          rdata_q <= (fault || we_q) ? 32'h0 : read_word;
          state_q <= MEM_DONE;
        end
        default: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= 32'h0;
          state_q <= MEM_IDLE;
        end
      endcase
    end
  end

endmodule
